// File: rtl/dispense_indicator.sv
// Product-dispense LED indicator: shows a one-hot (optionally blinking) LED for a
// fixed hold time, flags invalid selections, and buffers one request while busy.
module dispense_indicator #(
  parameter int NUM_PRODUCTS = 7,
  parameter int SEL_W        = 3,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dispense_req,
  input  logic [SEL_W-1:0]        product_sel,
  input  logic                    blink_en,
  output logic [NUM_PRODUCTS-1:0] led,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic                    drop,
  output logic [SEL_W-1:0]        active_sel
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [SEL_W-1:0] MAX_SEL    = SEL_W'(NUM_PRODUCTS);

  typedef enum logic [1:0] {IDLE, SHOW, FAULT} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic              cur_blink_q, cur_blink_d;
  logic              pend_valid_q, pend_valid_d;
  logic [SEL_W-1:0]  pend_sel_q, pend_sel_d;
  logic              pend_blink_q, pend_blink_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  logic              start_en;
  logic [SEL_W-1:0]  start_sel;
  logic              start_blink;
  logic              sel_ok;
  logic [NUM_PRODUCTS-1:0] one_hot;

  // State register: every register, including the pending slot, clears on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      cur_sel_q    <= '0;
      cur_blink_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_blink_q <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      hold_q       <= hold_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      cur_sel_q    <= cur_sel_d;
      cur_blink_q  <= cur_blink_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_blink_q <= pend_blink_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d      = state_q;
    hold_d       = hold_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    cur_sel_d    = cur_sel_q;
    cur_blink_d  = cur_blink_q;
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    pend_blink_d = pend_blink_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
    start_en     = 1'b0;
    start_sel    = product_sel;
    start_blink  = blink_en;
    sel_ok       = 1'b0;

    if (state_q == IDLE) begin
      start_en = dispense_req;
    end else begin
      hold_d = hold_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end

      if (hold_q == HOLD_LAST) begin
        done_d  = 1'b1;
        state_d = IDLE;
        // Final cycle: the pending entry starts and a coincident request refills the slot.
        if (pend_valid_q) begin
          start_en     = 1'b1;
          start_sel    = pend_sel_q;
          start_blink  = pend_blink_q;
          pend_valid_d = dispense_req;
          pend_sel_d   = product_sel;
          pend_blink_d = blink_en;
        end else begin
          start_en = dispense_req;
        end
      end else if (dispense_req) begin
        if (pend_valid_q) begin
          drop_d = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_sel_d   = product_sel;
          pend_blink_d = blink_en;
        end
      end
    end

    if (start_en) begin
      sel_ok      = (start_sel != '0) && (start_sel <= MAX_SEL);
      state_d     = sel_ok ? SHOW : FAULT;
      cur_sel_d   = sel_ok ? start_sel : '0;
      cur_blink_d = sel_ok & start_blink;
      hold_d      = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end
  end

  // Outputs depend only on registers, so there is no input-to-output path.
  always_comb begin
    one_hot = '0;
    for (int k = 0; k < NUM_PRODUCTS; k++) begin
      one_hot[k] = (cur_sel_q == SEL_W'(k + 1));
    end

    led        = '0;
    busy       = 1'b0;
    fault      = 1'b0;
    active_sel = '0;
    done       = done_q;
    drop       = drop_q;

    case (state_q)
      SHOW: begin
        busy       = 1'b1;
        active_sel = cur_sel_q;
        led        = (cur_blink_q && !phase_q) ? '0 : one_hot;
      end
      FAULT: begin
        busy  = 1'b1;
        fault = 1'b1;
        led   = '1;
      end
      default: begin
        led = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dispense_indicator.sv
// Bench for dispense_indicator: directed scenarios plus random traffic on two
// instances (7 and 6 products), each compared every cycle to a behavioural model.
module tb_dispense_indicator;

  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n, req, blink_en;
  logic [2:0] sel;

  logic [6:0] led0;
  logic [5:0] led1;
  logic       busy0, done0, fault0, drop0;
  logic       busy1, done1, fault1, drop1;
  logic [2:0] asel0, asel1;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  dispense_indicator #(.NUM_PRODUCTS(7), .SEL_W(3), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dispense_req(req), .product_sel(sel), .blink_en(blink_en),
    .led(led0), .busy(busy0), .done(done0), .fault(fault0), .drop(drop0), .active_sel(asel0)
  );

  dispense_indicator #(.NUM_PRODUCTS(6), .SEL_W(3), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dispense_req(req), .product_sel(sel), .blink_en(blink_en),
    .led(led1), .busy(busy1), .done(done1), .fault(fault1), .drop(drop1), .active_sel(asel1)
  );

  // Model: an active indication is (kind, sel, blink, elapsed cycles); pending is one slot.
  typedef struct {
    bit active;
    bit is_fault;
    bit blink;
    int sel;
    int e;
    bit pv;
    int psel;
    bit pblink;
    bit done;
    bit drop;
  } model_t;

  model_t m[2];
  int     num_p[2] = '{7, 6};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_start(input int i, input int s, input bit b);
    m[i].active   = 1'b1;
    m[i].is_fault = !(s >= 1 && s <= num_p[i]);
    m[i].sel      = s;
    m[i].blink    = b;
    m[i].e        = 0;
  endtask

  task automatic model_step(input int i, input bit rst_v, input bit r, input int s, input bit b);
    bit ended;
    if (!rst_v) begin
      m[i] = '{default: 0};
      return;
    end
    m[i].done = 1'b0;
    m[i].drop = 1'b0;
    ended = m[i].active && (m[i].e == HOLD - 1);
    if (m[i].active && !ended) m[i].e++;
    if (ended) begin
      m[i].done   = 1'b1;
      m[i].active = 1'b0;
      if (m[i].pv) begin
        model_start(i, m[i].psel, m[i].pblink);
        m[i].pv     = r;
        m[i].psel   = s;
        m[i].pblink = b;
      end else if (r) begin
        model_start(i, s, b);
      end
    end else if (!m[i].active) begin
      if (r) model_start(i, s, b);
    end else if (r) begin
      if (m[i].pv) begin
        m[i].drop = 1'b1;
      end else begin
        m[i].pv     = 1'b1;
        m[i].psel   = s;
        m[i].pblink = b;
      end
    end
  endtask

  function automatic logic [7:0] exp_led(input int i);
    if (!m[i].active) return 8'h00;
    if (m[i].is_fault) return 8'((1 << num_p[i]) - 1);
    if (!m[i].blink || ((m[i].e / BLINK) % 2 == 0)) return 8'(1 << (m[i].sel - 1));
    return 8'h00;
  endfunction

  function automatic logic [2:0] exp_sel(input int i);
    return (m[i].active && !m[i].is_fault) ? 3'(m[i].sel) : 3'd0;
  endfunction

  task automatic cycle(input bit rst_v, input bit r, input int s, input bit b);
    rst_n    = rst_v;
    req      = r;
    sel      = 3'(s);
    blink_en = b;
    @(posedge clk);
    model_step(0, rst_v, r, s, b);
    model_step(1, rst_v, r, s, b);
    #1;
    check("d0.led",   led0,   exp_led(0));
    check("d0.busy",  busy0,  m[0].active);
    check("d0.done",  done0,  m[0].done);
    check("d0.fault", fault0, m[0].active && m[0].is_fault);
    check("d0.drop",  drop0,  m[0].drop);
    check("d0.asel",  asel0,  exp_sel(0));
    check("d1.led",   led1,   exp_led(1));
    check("d1.busy",  busy1,  m[1].active);
    check("d1.done",  done1,  m[1].done);
    check("d1.fault", fault1, m[1].active && m[1].is_fault);
    check("d1.drop",  drop1,  m[1].drop);
    check("d1.asel",  asel1,  exp_sel(1));
    if (drop0) drop_cnt++;
    if (done0) done_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; sel = '0; blink_en = 1'b0;
    cycle(1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("rst.led", led0, 0);
    check("rst.busy", busy0, 0);
    check("rst.asel", asel0, 0);

    // Steady show of product 3
    cycle(1'b1, 1'b1, 3, 1'b0);
    check("s1.led", led0, 7'b0000100);
    check("s1.asel", asel0, 3);
    idle(7);
    check("s1.last_busy", busy0, 1);
    idle(1);
    check("s1.done", done0, 1);
    check("s1.idle_led", led0, 0);
    idle(2);

    // Blinking show of product 5
    cycle(1'b1, 1'b1, 5, 1'b1);
    check("s2.led_on", led0, 7'b0010000);
    idle(2);
    check("s2.led_off", led0, 7'b0000000);
    idle(8);

    // Invalid selections
    cycle(1'b1, 1'b1, 0, 1'b1);
    check("s3.fault0", fault0, 1);
    check("s3.led0_all", led0, 7'h7f);
    idle(10);
    cycle(1'b1, 1'b1, 7, 1'b0);
    check("s3.fault1", fault1, 1);
    check("s3.led1_all", led1, 6'h3f);
    check("s3.led0_sel7", led0, 7'b1000000);
    idle(10);

    // Pending capture and drop
    drop_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, 1, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 2, 1'b0);
    cycle(1'b1, 1'b1, 4, 1'b0);
    idle(20);
    check("s4.drops", drop_cnt, 1);
    check("s4.dones", done_cnt, 2);

    // Request in the final cycle starts back-to-back
    drop_cnt = 0;
    cycle(1'b1, 1'b1, 1, 1'b0);
    idle(7);
    cycle(1'b1, 1'b1, 6, 1'b0);
    check("s5.led_next", led0, 7'b0100000);
    check("s5.done", done0, 1);
    idle(10);
    check("s5.drops", drop_cnt, 0);

    // Reset mid-indication with pending full
    cycle(1'b1, 1'b1, 1, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 2, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("s6.led", led0, 0);
    check("s6.busy", busy0, 0);
    done_cnt = 0;
    idle(12);
    check("s6.no_done", done_cnt, 0);
    cycle(1'b1, 1'b1, 2, 1'b0);
    check("s6.led_after", led0, 7'b0000010);
    idle(10);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
